// File: rtl/jtframe_keymap_pkg.sv
// Shared constants for the cabinet-input mapper: PS/2 scan codes, joystick
// vector bit positions and the coin-stretch state type.
package jtframe_keymap_pkg;

   localparam logic [7:0] KEY_UP       = 8'h75;
   localparam logic [7:0] KEY_DOWN     = 8'h72;
   localparam logic [7:0] KEY_LEFT     = 8'h6B;
   localparam logic [7:0] KEY_RIGHT    = 8'h74;
   localparam logic [7:0] KEY_BTN0     = 8'h14;
   localparam logic [7:0] KEY_BTN1     = 8'h11;
   localparam logic [7:0] KEY_BTN2     = 8'h29;
   localparam logic [7:0] KEY_P2_UP    = 8'h2D;
   localparam logic [7:0] KEY_P2_DOWN  = 8'h2B;
   localparam logic [7:0] KEY_P2_LEFT  = 8'h23;
   localparam logic [7:0] KEY_P2_RIGHT = 8'h34;
   localparam logic [7:0] KEY_P2_BTN0  = 8'h1C;
   localparam logic [7:0] KEY_P2_BTN1  = 8'h1B;
   localparam logic [7:0] KEY_F1       = 8'h05;
   localparam logic [7:0] KEY_F2       = 8'h06;
   localparam logic [7:0] KEY_F3       = 8'h04;
   localparam logic [7:0] KEY_F4       = 8'h0C;
   localparam logic [7:0] KEY_PAUSE    = 8'h4D;

   localparam int JOY_BTN0  = 4;
   localparam int JOY_START = 12;
   localparam int JOY_COIN  = 13;
   localparam int JOY_PAUSE = 14;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } coin_st_t;

endpackage

// File: rtl/jtframe_coin_stretch.sv
// Per-slot coin stretcher: a raw rising edge holds the slot active for at
// least COIN_W cycles, and for as long as the raw input stays high.
module jtframe_coin_stretch
   import jtframe_keymap_pkg::*;
#(
   parameter int COIN_W = 400000
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_raw,
   output coin_st_t o_state
);

   localparam int CW = $clog2(COIN_W + 1);

   coin_st_t      r_state;
   coin_st_t      w_state_nx;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nx;
   logic          r_raw_d;
   logic          w_rise;

   assign w_rise  = i_raw & ~r_raw_d;
   assign o_state = r_state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_raw_d <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_raw_d <= i_raw;
      end
   end

   // Edges seen while in HOLD are deliberately ignored: the window never restarts.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_nx = HOLD;
               w_cnt_nx   = CW'(COIN_W - 1);
            end
         end
         HOLD: begin
            if (r_cnt != '0) begin
               w_cnt_nx = r_cnt - CW'(1);
            end else if (!i_raw) begin
               w_state_nx = IDLE;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

endmodule

// File: rtl/jtframe_keymap.sv
// Cabinet-input mapper: merges PS/2 key state with per-player joystick vectors
// into registered active-low controls, stretched coins and a pause flag.
module jtframe_keymap
   import jtframe_keymap_pkg::*;
#(
   parameter int NPL    = 2,
   parameter int NBUT   = 2,
   parameter int COIN_W = 400000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [10:0]               ps2_key,
   input  logic [NPL*16-1:0]         joy,
   input  logic                      pause_clr,
   output logic [NPL*(4+NBUT)-1:0]   joystick,
   output logic [NPL-1:0]            start,
   output logic [NPL-1:0]            coin,
   output logic                      pause
);

   localparam int PW = 4 + NBUT;
   localparam int JW = NPL * PW;

   logic          r_armed;
   logic          r_old_tog;
   logic          w_event;

   logic [JW-1:0]  r_key_joy;
   logic [NPL-1:0] r_key_start;
   logic [NPL-1:0] r_key_coin;
   logic           r_key_pause;

   logic          w_kj_hit;
   logic [1:0]    w_kj_pl;
   logic [3:0]    w_kj_bit;
   logic          w_st_hit;
   logic [1:0]    w_st_idx;
   logic          w_cn_hit;
   logic [1:0]    w_cn_idx;
   logic          w_pause_hit;

   logic [JW-1:0]  w_joy_flat;
   logic [NPL-1:0] w_start_raw;
   logic [NPL-1:0] w_coin_raw;
   logic [NPL-1:0] w_joy_pause;
   logic           w_pause_src;
   logic           w_unused_bits;

   logic [JW-1:0]  r_joystick;
   logic [NPL-1:0] r_start;
   logic           r_pause;
   logic           r_pause_src_d;

   coin_st_t      w_coin_st [NPL];

   // ps2_key[10] flips once per key event; the first cycle after reset only
   // samples it so a stale toggle level is never taken as an event.
   assign w_event = r_armed & (ps2_key[10] ^ r_old_tog);

   assign w_unused_bits = ^{ps2_key[8], joy};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed   <= 1'b0;
         r_old_tog <= 1'b0;
      end else begin
         r_armed   <= 1'b1;
         r_old_tog <= ps2_key[10];
      end
   end

   always_comb begin
      w_kj_hit    = 1'b0;
      w_kj_pl     = 2'd0;
      w_kj_bit    = 4'd0;
      w_st_hit    = 1'b0;
      w_st_idx    = 2'd0;
      w_cn_hit    = 1'b0;
      w_cn_idx    = 2'd0;
      w_pause_hit = 1'b0;
      case (ps2_key[7:0])
         KEY_RIGHT:    begin w_kj_hit = 1'b1; w_kj_bit = 4'd0; end
         KEY_LEFT:     begin w_kj_hit = 1'b1; w_kj_bit = 4'd1; end
         KEY_DOWN:     begin w_kj_hit = 1'b1; w_kj_bit = 4'd2; end
         KEY_UP:       begin w_kj_hit = 1'b1; w_kj_bit = 4'd3; end
         KEY_BTN0:     begin w_kj_hit = 1'b1; w_kj_bit = 4'd4; end
         KEY_BTN1:     begin w_kj_hit = 1'b1; w_kj_bit = 4'd5; end
         KEY_BTN2:     begin w_kj_hit = 1'b1; w_kj_bit = 4'd6; end
         KEY_P2_RIGHT: begin w_kj_hit = 1'b1; w_kj_pl = 2'd1; w_kj_bit = 4'd0; end
         KEY_P2_LEFT:  begin w_kj_hit = 1'b1; w_kj_pl = 2'd1; w_kj_bit = 4'd1; end
         KEY_P2_DOWN:  begin w_kj_hit = 1'b1; w_kj_pl = 2'd1; w_kj_bit = 4'd2; end
         KEY_P2_UP:    begin w_kj_hit = 1'b1; w_kj_pl = 2'd1; w_kj_bit = 4'd3; end
         KEY_P2_BTN0:  begin w_kj_hit = 1'b1; w_kj_pl = 2'd1; w_kj_bit = 4'd4; end
         KEY_P2_BTN1:  begin w_kj_hit = 1'b1; w_kj_pl = 2'd1; w_kj_bit = 4'd5; end
         KEY_F1:       begin w_st_hit = 1'b1; w_st_idx = 2'd0; end
         KEY_F2:       begin w_st_hit = 1'b1; w_st_idx = 2'd1; end
         KEY_F3:       begin w_cn_hit = 1'b1; w_cn_idx = 2'd0; end
         KEY_F4:       begin w_cn_hit = 1'b1; w_cn_idx = 2'd1; end
         KEY_PAUSE:    w_pause_hit = 1'b1;
         default: ;
      endcase
   end

   // Loops run only over implemented players/buttons, so keys mapped beyond
   // NPL or NBUT simply find no register to load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_joy   <= '0;
         r_key_start <= '0;
         r_key_coin  <= '0;
         r_key_pause <= 1'b0;
      end else if (w_event) begin
         for (int p = 0; p < NPL; p++) begin
            for (int b = 0; b < PW; b++) begin
               if (w_kj_hit && w_kj_pl == 2'(p) && w_kj_bit == 4'(b))
                  r_key_joy[p*PW + b] <= ps2_key[9];
            end
            if (w_st_hit && w_st_idx == 2'(p)) r_key_start[p] <= ps2_key[9];
            if (w_cn_hit && w_cn_idx == 2'(p)) r_key_coin[p]  <= ps2_key[9];
         end
         if (w_pause_hit) r_key_pause <= ps2_key[9];
      end
   end

   genvar g;
   for (g = 0; g < NPL; g++) begin : g_pl
      assign w_joy_flat[g*PW +: 4]      = joy[g*16 +: 4];
      assign w_joy_flat[g*PW + 4 +: NBUT] = joy[g*16 + JOY_BTN0 +: NBUT];
      assign w_start_raw[g] = r_key_start[g] | joy[g*16 + JOY_START];
      assign w_coin_raw[g]  = r_key_coin[g]  | joy[g*16 + JOY_COIN];
      assign w_joy_pause[g] = joy[g*16 + JOY_PAUSE];

      jtframe_coin_stretch #(
         .COIN_W (COIN_W)
      ) u_coin (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .i_raw   (w_coin_raw[g]),
         .o_state (w_coin_st[g])
      );

      assign coin[g] = (w_coin_st[g] != HOLD);
   end

   assign w_pause_src = r_key_pause | (|w_joy_pause);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_joystick    <= '1;
         r_start       <= '1;
         r_pause       <= 1'b0;
         r_pause_src_d <= 1'b0;
      end else begin
         r_joystick    <= ~(r_key_joy | w_joy_flat);
         r_start       <= ~w_start_raw;
         r_pause_src_d <= w_pause_src;
         if (pause_clr)
            r_pause <= 1'b0;
         else if (w_pause_src && !r_pause_src_d)
            r_pause <= ~r_pause;
      end
   end

   assign joystick = r_joystick;
   assign start    = r_start;
   assign pause    = r_pause;

endmodule

// File: tb/tb_jtframe_keymap.sv
// Directed bench for jtframe_keymap: a 4-player/3-button instance with a short
// coin window, plus a 1-player/1-button instance for out-of-range key mapping.
module tb_jtframe_keymap;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] ps2_key;
   logic [63:0] joy0;
   logic [15:0] joy1;
   logic        pause_clr;

   logic [27:0] joystick0;
   logic [3:0]  start0;
   logic [3:0]  coin0;
   logic        pause0;
   logic [4:0]  joystick1;
   logic        start1;
   logic        coin1;
   logic        pause1;

   int n_checks = 0;
   int n_err    = 0;
   int lowc;

   always #5 clk = ~clk;

   jtframe_keymap #(.NPL(4), .NBUT(3), .COIN_W(8)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_key   (ps2_key),
      .joy       (joy0),
      .pause_clr (pause_clr),
      .joystick  (joystick0),
      .start     (start0),
      .coin      (coin0),
      .pause     (pause0)
   );

   jtframe_keymap #(.NPL(1), .NBUT(1), .COIN_W(8)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2_key   (ps2_key),
      .joy       (joy1),
      .pause_clr (pause_clr),
      .joystick  (joystick1),
      .start     (start1),
      .coin      (coin1),
      .pause     (pause1)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_key(input logic pressed, input logic [7:0] code);
      ps2_key = {~ps2_key[10], pressed, 1'b0, code};
   endtask

   // Drives joy0[13] from pat one cycle per bit and counts cycles coin0[0] is low.
   task automatic coin_run(input logic [15:0] pat, output int low_cycles);
      low_cycles = 0;
      for (int i = 0; i < 16; i++) begin
         joy0[13] = pat[i];
         tick(1);
         if (coin0[0] == 1'b0) low_cycles++;
      end
      joy0[13] = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      ps2_key   = 11'h400;
      joy0      = '0;
      joy1      = '0;
      pause_clr = 1'b0;
      tick(3);
      chk("rst_joystick", joystick0, 28'hFFFFFFF);
      chk("rst_start",    start0,    4'hF);
      chk("rst_coin",     coin0,     4'hF);
      chk("rst_pause",    pause0,    1'b0);
      chk("rst_joystick1", joystick1, 5'h1F);

      rst_n = 1'b1;
      tick(3);
      chk("arm_no_event", joystick0, 28'hFFFFFFF);

      send_key(1'b1, 8'h75);
      tick(1);
      chk("up_lat1", joystick0, 28'hFFFFFFF);
      tick(1);
      chk("up_press", joystick0, 28'hFFFFFF7);
      chk("up_press_d1", joystick1, 5'h17);
      send_key(1'b0, 8'h75);
      tick(1);
      chk("up_rel_lat1", joystick0, 28'hFFFFFF7);
      tick(1);
      chk("up_release", joystick0, 28'hFFFFFFF);

      send_key(1'b1, 8'h11);
      tick(2);
      chk("p1_btn1", joystick0, 28'hFFFFFDF);
      chk("p1_btn1_nbut1", joystick1, 5'h1F);
      send_key(1'b0, 8'h11);
      tick(2);

      send_key(1'b1, 8'h29);
      tick(2);
      chk("p1_btn2", joystick0, 28'hFFFFFBF);
      send_key(1'b0, 8'h29);
      tick(2);

      send_key(1'b1, 8'h14);
      tick(2);
      chk("p1_btn0_d1", joystick1, 5'h0F);
      send_key(1'b0, 8'h14);
      tick(2);

      send_key(1'b1, 8'h2D);
      tick(2);
      chk("p2_up", joystick0, 28'hFFFFBFF);
      send_key(1'b0, 8'h2D);
      tick(2);

      send_key(1'b1, 8'h1B);
      tick(2);
      chk("p2_btn1", joystick0, 28'hFFFEFFF);
      chk("p2_btn1_npl1", joystick1, 5'h1F);
      send_key(1'b0, 8'h1B);
      tick(2);
      chk("keys_released", joystick0, 28'hFFFFFFF);

      joy0[2*16+6] = 1'b1;
      tick(1);
      chk("p3_joy_btn2", joystick0, 28'hFEFFFFF);
      joy0[2*16+6] = 1'b0;
      tick(1);
      chk("p3_joy_rel", joystick0, 28'hFFFFFFF);

      joy0[0] = 1'b1;
      tick(1);
      chk("both_joy", joystick0, 28'hFFFFFFE);
      send_key(1'b1, 8'h74);
      tick(2);
      chk("both_key", joystick0, 28'hFFFFFFE);
      joy0[0] = 1'b0;
      tick(1);
      chk("both_joy_rel", joystick0, 28'hFFFFFFE);
      send_key(1'b0, 8'h74);
      tick(2);
      chk("both_key_rel", joystick0, 28'hFFFFFFF);

      joy0[16+12] = 1'b1;
      tick(1);
      chk("start2_joy", start0, 4'hD);
      joy0[16+12] = 1'b0;
      send_key(1'b1, 8'h05);
      tick(2);
      chk("start1_key", start0, 4'hE);
      send_key(1'b0, 8'h05);
      tick(2);
      chk("start_rel", start0, 4'hF);

      coin_run(16'h0001, lowc);
      chk("coin_pulse_width", lowc, 8);
      coin_run(16'h0009, lowc);
      chk("coin_no_restart", lowc, 8);

      joy0[13] = 1'b1;
      tick(10);
      chk("coin_held_mid", coin0, 4'hE);
      tick(10);
      joy0[13] = 1'b0;
      chk("coin_held_end", coin0, 4'hE);
      tick(1);
      chk("coin_held_rel", coin0, 4'hF);

      send_key(1'b1, 8'h04);
      tick(2);
      chk("coin1_key", coin0, 4'hE);
      send_key(1'b0, 8'h04);
      tick(10);
      chk("coin1_key_done", coin0, 4'hF);
      joy0[16+13] = 1'b1;
      tick(1);
      joy0[16+13] = 1'b0;
      chk("coin2_joy", coin0, 4'hD);
      tick(10);

      joy0[13] = 1'b1;
      tick(1);
      joy0[13] = 1'b0;
      tick(2);
      chk("coin_hold_pre_rst", coin0, 4'hE);
      rst_n = 1'b0;
      #1;
      chk("coin_async_rst", coin0, 4'hF);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      coin_run(16'h0001, lowc);
      chk("coin_after_rst", lowc, 8);

      send_key(1'b1, 8'h4D);
      tick(1);
      chk("pause_lat1", pause0, 1'b0);
      tick(1);
      chk("pause_on", pause0, 1'b1);
      send_key(1'b0, 8'h4D);
      tick(2);
      chk("pause_rel_keep", pause0, 1'b1);
      send_key(1'b1, 8'h4D);
      tick(2);
      chk("pause_off", pause0, 1'b0);
      send_key(1'b0, 8'h4D);
      tick(2);

      joy0[16+14] = 1'b1;
      tick(1);
      chk("pause_joy_on", pause0, 1'b1);
      joy0[16+14] = 1'b0;
      tick(2);
      chk("pause_joy_keep", pause0, 1'b1);
      joy0[16+14] = 1'b1;
      pause_clr   = 1'b1;
      tick(1);
      chk("pause_clr_wins", pause0, 1'b0);
      pause_clr   = 1'b0;
      joy0[16+14] = 1'b0;
      tick(2);
      chk("pause_stays_off", pause0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/jtframe_keymap.md
Name: jtframe_keymap

Overview:
- Parametrised cabinet-input mapper between the platform I/O block and any game core.
- Decodes PS/2 key events and merges them with per-player joystick vectors.
- Generates registered active-low player controls, starts and coins, a toggled pause flag, and minimum-width coin pulses.
- Supports 1–4 players and 1–8 buttons per player.

Parameters:
- NPL, 2, number of players (1..4).
- NBUT, 2, buttons per player (1..8).
- COIN_W, 400000, minimum coin-active width in clk cycles (10 ms at 40 MHz); counter width is $clog2(COIN_W+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scan code.
- joy  in  NPL*16  per-player 16-bit vector, active high: [0] right, [1] left, [2] down, [3] up, [4+:NBUT] buttons, [12] start, [13] coin, [14] pause.
- pause_clr  in  1  synchronous clear of the pause flag.
- joystick  out  NPL*(4+NBUT)  active low; per player packed {buttons[NBUT-1:0], up, down, left, right}; player 0 in the LSBs.
- start  out  NPL  active low, bit n = player n+1.
- coin  out  NPL  active low, stretched, bit n = coin slot n+1.
- pause  out  1  active-high pause flag.

Behaviour:
- Reset values: all key-state regs 0; joystick, start and coin all 1s; pause 0; coin counters 0; armed 0.
- Event detection: old_tog register holds the previous ps2_key[10].
  - armed is 0 on the first cycle after reset: old_tog is sampled, no decode, and armed is set to 1.
  - Once armed, ps2_key[10] != old_tog is a key event; the mapped key-state reg is loaded with ps2_key[9].
  - Unmapped codes are ignored.
- Keyboard map:
  - P1: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x14 btn0, 0x11 btn1, 0x29 btn2.
  - P2 (when NPL>=2): 0x2D up, 0x2B down, 0x23 left, 0x34 right, 0x1C btn0, 0x1B btn1.
  - Starts: 0x05 start1, 0x06 start2.
  - Coins: 0x04 coin1, 0x0C coin2.
  - Pause: 0x4D.
  - Any key mapped to a button index >= NBUT or a player index >= NPL is ignored.
  - Players 3 and 4 are joystick-only.
- Merge: each output = ~(key_state | joy bit), registered once.
  - Latency from a ps2_key event to the output is 2 cycles.
  - Latency from a joy change to the output is 1 cycle.
- Coin stretch (per slot):
  - States: IDLE, HOLD.
  - IDLE: on raw coin (key | joy[13]) going 0->1, enter HOLD with cnt=COIN_W-1 and drive coin low on the next cycle.
  - HOLD: cnt decrements each cycle. When cnt==0 and raw is 0, return to IDLE and drive coin high. If raw is still 1 at cnt==0, hold at cnt 0 until raw falls.
  - A new rising edge during HOLD does not restart the count.
- Pause:
  - pause_src = key 0x4D | OR of all joy[14].
  - A rising edge of pause_src toggles pause one cycle later.
  - pause_clr forces 0; on a simultaneous toggle and clear, the clear wins.
- Simultaneous key and joystick press: the output is active if either source is active. Releasing one source keeps the output active while the other is held.
- Reset asserted mid-operation: all state returns to reset values immediately, including abandoning a HOLD.
- Event-toggle wrap is inherent: the 1-bit toggle is compared by inequality only.

Decomposition:
- jtframe_keymap_pkg holds:
  - scan-code localparams (KEY_UP, KEY_P2_UP, KEY_F1, …);
  - joy bit-position constants (JOY_START=12, JOY_COIN=13, JOY_PAUSE=14, JOY_BTN0=4);
  - a typedef enum for the coin FSM {IDLE, HOLD}.
- Sub-module jtframe_coin_stretch (one instance per slot via generate): the coin FSM plus counter.

Test Plan:
- Release reset with ps2_key[10]=1 and no events -> no output changes; joystick stays all 1s.
- Toggle ps2_key with {pressed=1, code 0x75} -> P1 up bit goes 0 exactly 2 cycles later. Same event with pressed=0 -> up bit returns to 1 after 2 cycles.
- COIN_W=8: one-cycle joy[13] pulse -> coin[0]=0 for exactly 8 cycles. Raw coin held for 20 cycles -> coin[0]=0 until 1 cycle after raw falls.
- Press 0x4D twice, with a release between presses -> pause 0->1->0. Assert pause_clr on the same cycle as a toggle edge while pause=1 -> pause stays 0.
- NPL=4, NBUT=3: joy P3 btn2 high -> joystick bit [2*7+6] goes 0 after 1 cycle. Key 0x11 drives P1 btn1. Key 0x1B with NBUT=1 -> no change.
- Assert rst_n low during a coin HOLD -> coin goes 1 immediately. After release, the counter restarts from IDLE.
